// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction memory port, redirect request and the decode handshake.
interface fetch_unit_if #(
  parameter int n = 32
);
  logic [n-1:0] address;
  logic [n-1:0] instruction;
  logic         redirect_valid;
  logic [n-1:0] redirect_target;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_pc;
  logic [n-1:0] out_instr;

  modport master (
    output address,
    input  instruction,
    input  redirect_valid,
    input  redirect_target,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr
  );

  modport slave (
    input  address,
    output instruction,
    output redirect_valid,
    output redirect_target,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register feeding a 2-entry {pc, instr} queue toward decode.
// The head/tail registers are kept at zero whenever unused, so outputs come straight from flops.
module fetch_unit #(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = n'(32'h0000_0000)
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [n-1:0] pc_step    = n'(32'd4);
  localparam logic [n-1:0] align_mask = ~n'(32'd3);
  localparam logic [n-1:0] zero_word  = {n{1'b0}};

  state_t       state_r, state_nxt_s;
  logic [n-1:0] pc_r, pc_nxt_s;
  logic [n-1:0] head_pc_r, head_pc_nxt_s;
  logic [n-1:0] head_instr_r, head_instr_nxt_s;
  logic [n-1:0] tail_pc_r, tail_pc_nxt_s;
  logic [n-1:0] tail_instr_r, tail_instr_nxt_s;
  logic         valid_s, deq_s, push_s;

  assign bus.address   = pc_r;
  assign bus.out_valid = valid_s;
  assign bus.out_pc    = head_pc_r;
  assign bus.out_instr = head_instr_r;

  // Handshake decode: a push needs a free slot (or one being freed) and no redirect.
  always_comb begin
    valid_s = (state_r != EMPTY);
    deq_s   = valid_s & bus.out_ready;
    push_s  = ((state_r != FULL) | deq_s) & ~bus.redirect_valid;
  end

  // Next-state, PC and queue contents; a redirect flushes and wins over push/deq.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    head_pc_nxt_s    = head_pc_r;
    head_instr_nxt_s = head_instr_r;
    tail_pc_nxt_s    = tail_pc_r;
    tail_instr_nxt_s = tail_instr_r;
    if (bus.redirect_valid) begin
      state_nxt_s      = EMPTY;
      pc_nxt_s         = bus.redirect_target & align_mask;
      head_pc_nxt_s    = zero_word;
      head_instr_nxt_s = zero_word;
      tail_pc_nxt_s    = zero_word;
      tail_instr_nxt_s = zero_word;
    end else begin
      if (push_s) begin
        pc_nxt_s = pc_r + pc_step;
      end else begin
        pc_nxt_s = pc_r;
      end
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            state_nxt_s      = ONE;
            head_pc_nxt_s    = pc_r;
            head_instr_nxt_s = bus.instruction;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (push_s && deq_s) begin
            state_nxt_s      = ONE;
            head_pc_nxt_s    = pc_r;
            head_instr_nxt_s = bus.instruction;
          end else if (push_s) begin
            state_nxt_s      = FULL;
            tail_pc_nxt_s    = pc_r;
            tail_instr_nxt_s = bus.instruction;
          end else if (deq_s) begin
            state_nxt_s      = EMPTY;
            head_pc_nxt_s    = zero_word;
            head_instr_nxt_s = zero_word;
          end else begin
            state_nxt_s = ONE;
          end
        end
        FULL: begin
          // Pop-and-append in one cycle keeps the pipe bubble-free.
          if (deq_s && push_s) begin
            state_nxt_s      = FULL;
            head_pc_nxt_s    = tail_pc_r;
            head_instr_nxt_s = tail_instr_r;
            tail_pc_nxt_s    = pc_r;
            tail_instr_nxt_s = bus.instruction;
          end else if (deq_s) begin
            state_nxt_s      = ONE;
            head_pc_nxt_s    = tail_pc_r;
            head_instr_nxt_s = tail_instr_r;
            tail_pc_nxt_s    = zero_word;
            tail_instr_nxt_s = zero_word;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          state_nxt_s      = EMPTY;
          head_pc_nxt_s    = zero_word;
          head_instr_nxt_s = zero_word;
          tail_pc_nxt_s    = zero_word;
          tail_instr_nxt_s = zero_word;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= EMPTY;
      pc_r         <= RESET_PC;
      head_pc_r    <= zero_word;
      head_instr_r <= zero_word;
      tail_pc_r    <= zero_word;
      tail_instr_r <= zero_word;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      head_pc_r    <= head_pc_nxt_s;
      head_instr_r <= head_instr_nxt_s;
      tail_pc_r    <= tail_pc_nxt_s;
      tail_instr_r <= tail_instr_nxt_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboard of the expected fetch stream plus directed timing checks.
module tb_fetch_unit;

  localparam logic [31:0] RST0     = 32'h0000_0000;
  localparam logic [31:0] RST1     = 32'hFFFF_FFF8;
  localparam logic [31:0] MEM_MASK = 32'hC0DE_0000;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  bit   rst_seen;
  bit   hold_prev;
  logic [31:0] prev_pc, prev_instr, exp_pc;
  logic [31:0] sb0[$];
  logic [31:0] sb1[$];

  fetch_unit_if #(.n(32)) bus0 ();
  fetch_unit_if #(.n(32)) bus1 ();

  fetch_unit #(.n(32), .RESET_PC(RST0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  fetch_unit #(.n(32), .RESET_PC(RST1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  // Instruction memory: word at byte address k is k ^ MEM_MASK, so pc and instr differ.
  assign bus0.instruction = bus0.address ^ MEM_MASK;
  assign bus1.instruction = bus1.address ^ MEM_MASK;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: refill on reset/redirect, pop and compare on every accepted entry.
  always @(negedge clk) begin
    if (!reset_n) begin
      rst_seen  = 1'b1;
      hold_prev = 1'b0;
      sb0.delete();
      sb1.delete();
      for (int i = 0; i < 256; i++) begin
        sb0.push_back(RST0 + 32'(i * 4));
        sb1.push_back(RST1 + 32'(i * 4));
      end
    end else if (rst_seen) begin
      if (bus0.out_valid !== 1'b1) begin
        check_eq("empty_pc", bus0.out_pc, 32'h0);
        check_eq("empty_instr", bus0.out_instr, 32'h0);
      end
      if (hold_prev) begin
        check_eq("hold_valid", {31'b0, bus0.out_valid}, 32'd1);
        check_eq("hold_pc", bus0.out_pc, prev_pc);
        check_eq("hold_instr", bus0.out_instr, prev_instr);
      end
      if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
        check_eq("sb0_nonempty", 32'(sb0.size() != 0), 32'd1);
        if (sb0.size() != 0) begin
          exp_pc = sb0.pop_front();
          check_eq("sb0_pc", bus0.out_pc, exp_pc);
          check_eq("sb0_instr", bus0.out_instr, exp_pc ^ MEM_MASK);
        end
      end
      hold_prev  = (bus0.out_valid === 1'b1) && !bus0.out_ready && !bus0.redirect_valid;
      prev_pc    = bus0.out_pc;
      prev_instr = bus0.out_instr;
      if (bus0.redirect_valid) begin
        sb0.delete();
        for (int i = 0; i < 256; i++) sb0.push_back((bus0.redirect_target & 32'hFFFF_FFFC) + 32'(i * 4));
      end
      if (bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
        check_eq("sb1_nonempty", 32'(sb1.size() != 0), 32'd1);
        if (sb1.size() != 0) begin
          exp_pc = sb1.pop_front();
          check_eq("sb1_pc", bus1.out_pc, exp_pc);
          check_eq("sb1_instr", bus1.out_instr, exp_pc ^ MEM_MASK);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_seen = 1'b0;
    hold_prev = 1'b0;
    reset_n = 1'b0;
    bus0.out_ready = 1'b0;
    bus0.redirect_valid = 1'b0;
    bus0.redirect_target = 32'h0;
    bus1.out_ready = 1'b1;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_target = 32'h0;
    tick();
    tick();
    check_eq("rst_valid", {31'b0, bus0.out_valid}, 32'd0);
    check_eq("rst_pc", bus0.out_pc, 32'h0);
    check_eq("rst_instr", bus0.out_instr, 32'h0);
    check_eq("rst_addr", bus0.address, RST0);
    check_eq("rst_addr1", bus1.address, RST1);

    // Streaming at full rate from reset release; dut1 exercises the PC wrap.
    reset_n = 1'b1;
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("stream_valid", {31'b0, bus0.out_valid}, 32'd1);
      check_eq("stream_pc", bus0.out_pc, 32'(k * 4));
      check_eq("wrap_pc", bus1.out_pc, RST1 + 32'(k * 4));
    end

    // Stall after reset: queue fills, PC parks at 8, head stays 0, then drains without gap.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus0.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check_eq("stall_addr", bus0.address, 32'h8);
    check_eq("stall_pc", bus0.out_pc, 32'h0);
    check_eq("stall_valid", {31'b0, bus0.out_valid}, 32'd1);
    bus0.out_ready = 1'b1;
    tick();
    check_eq("drain_pc4", bus0.out_pc, 32'h4);
    tick();
    check_eq("drain_pc8", bus0.out_pc, 32'h8);

    // Redirect while FULL and stalled.
    bus0.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    bus0.redirect_valid = 1'b1;
    bus0.redirect_target = 32'h0000_0103;
    tick();
    bus0.redirect_valid = 1'b0;
    check_eq("redir_full_valid", {31'b0, bus0.out_valid}, 32'd0);
    check_eq("redir_full_addr", bus0.address, 32'h0000_0100);
    tick();
    check_eq("redir_full_pc", bus0.out_pc, 32'h0000_0100);
    check_eq("redir_full_v", {31'b0, bus0.out_valid}, 32'd1);

    // Redirect coinciding with a deq in steady state (ONE).
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    bus0.redirect_valid = 1'b1;
    bus0.redirect_target = 32'h0000_0202;
    tick();
    bus0.redirect_valid = 1'b0;
    check_eq("redir_deq_valid", {31'b0, bus0.out_valid}, 32'd0);
    check_eq("redir_deq_addr", bus0.address, 32'h0000_0200);
    tick();
    check_eq("redir_deq_pc", bus0.out_pc, 32'h0000_0200);
    tick();
    check_eq("redir_deq_next", bus0.out_pc, 32'h0000_0204);

    // One-cycle reset while FULL discards queued entries.
    bus0.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    reset_n = 1'b0;
    tick();
    check_eq("mid_rst_valid", {31'b0, bus0.out_valid}, 32'd0);
    check_eq("mid_rst_pc", bus0.out_pc, 32'h0);
    check_eq("mid_rst_instr", bus0.out_instr, 32'h0);
    check_eq("mid_rst_addr", bus0.address, RST0);
    check_eq("mid_rst_addr1", bus1.address, RST1);
    reset_n = 1'b1;
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check_eq("post_rst_pc", bus0.out_pc, 32'h14);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: n, default 32, datapath and address width in bits.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, program counter value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 address  output  n  current PC, driven to the instruction memory's byte address input.
REQ-006 instruction  input  n  instruction word returned combinationally by the instruction memory for address.
REQ-007 redirect_valid  input  1  branch/jump taken; flush and reload PC.
REQ-008 redirect_target  input  n  new PC byte address when redirect_valid=1.
REQ-009 out_valid  output  1  head entry of fetch queue valid.
REQ-010 out_ready  input  1  decode stage accepts head entry.
REQ-011 out_pc  output  n  PC of head entry.
REQ-012 out_instr  output  n  instruction word of head entry.

Function
REQ-013 The block SHALL hold a PC register and a 2-entry FIFO of {pc, instruction} pairs, with occupancy count 0..2 (states EMPTY, ONE, FULL).
REQ-014 address SHALL equal the PC register combinationally, with no added latency.
REQ-015 deq SHALL be out_valid & out_ready; push SHALL be (count<2 | deq) & ~redirect_valid.
REQ-016 On push, the FIFO SHALL enqueue {PC, instruction} sampled that cycle, and PC SHALL become PC+4, modulo 2^n, wrapping silently.
REQ-017 When push=0 and redirect_valid=0, PC SHALL hold.
REQ-018 out_valid SHALL be 1 iff count!=0; out_pc/out_instr SHALL show the oldest entry and SHALL be all zeros when count=0.
REQ-019 Transitions SHALL be:
- EMPTY -> ONE on push.
- ONE -> FULL on push without deq.
- ONE stays ONE on push with deq.
- ONE -> EMPTY on deq without push.
- FULL stays FULL on deq with push.
- FULL stays FULL with no deq.
REQ-020 A head entry with out_valid=1 and out_ready=0 SHALL remain stable (pc and instr unchanged) until accepted.
REQ-021 Simultaneous deq and push in FULL SHALL pop the head and append the new entry in the same cycle, with no bubble.
REQ-022 On redirect_valid=1:
- the FIFO SHALL be flushed (count=0 next cycle), overriding any deq or push that cycle;
- PC SHALL load {redirect_target[n-1:2], 2'b00};
- out_valid SHALL be 0 in the following cycle.
REQ-023 A deq coinciding with redirect_valid SHALL still count as accepted by the consumer; the block SHALL NOT re-present that entry.
REQ-024 After a redirect, the first push SHALL occur in the next cycle, so the target instruction appears at out_* 2 cycles after redirect_valid is asserted.
REQ-025 Steady-state throughput SHALL be one instruction per cycle while out_ready=1.

Reset
REQ-026 While reset_n=0 at a rising edge:
- PC SHALL be RESET_PC;
- count SHALL be 0;
- out_valid SHALL be 0;
- out_pc and out_instr SHALL be 0.
REQ-027 Reset SHALL override redirect_valid, push and deq, and SHALL discard any queued entries mid-operation.
REQ-028 The first push SHALL occur in the first cycle with reset_n=1, fetching RESET_PC.

Verification
REQ-029 Reset, then out_ready=1, memory word at byte address k = k -> out_pc/out_instr sequence 0,4,8,12 on consecutive cycles, with out_valid high from cycle 1 after reset release.
REQ-030 out_ready=0 for 5 cycles after reset release -> count reaches 2, address holds 8, and out_pc stays 0. Then out_ready=1 -> out_pc 0,4,8 with no gap.
REQ-031 Redirect to 32'h0000_0103 while FULL with out_ready=0 -> next cycle out_valid=0 and address=32'h0000_0100; one cycle later out_pc=32'h100.
REQ-032 Redirect asserted in the same cycle as deq in state ONE -> the dequeued entry is not repeated, and the next valid out_pc equals the redirect target.
REQ-033 Set RESET_PC=32'hFFFF_FFF8 with out_ready=1 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
REQ-034 reset_n=0 for one cycle while FULL -> next cycle out_valid=0, out_pc=0, address=RESET_PC.
